// File: rtl/matrix_stream_reader_if.sv
// Memory-read and element-stream signals of matrix_stream_reader.
// The reader attaches to the slave modport and its environment to the master modport.
interface matrix_stream_reader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic              start;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] base_a;
  logic [ADDR_W-1:0] base_b;
  logic [ADDR_W-1:0] mem_a_addr;
  logic [ADDR_W-1:0] mem_b_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_a_rdata;
  logic [DATA_W-1:0] mem_b_rdata;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              done;

  modport master (
    output start, mode, base_a, base_b, mem_a_rdata, mem_b_rdata, out_ready,
    input  mem_a_addr, mem_b_addr, mem_rd_en, out_a, out_b, out_valid, out_last, busy, done
  );

  modport slave (
    input  start, mode, base_a, base_b, mem_a_rdata, mem_b_rdata, out_ready,
    output mem_a_addr, mem_b_addr, mem_rd_en, out_a, out_b, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/matrix_stream_reader.sv
// Streams an N x N matrix pair (A, B) element by element from two memories.
// Each matrix is read row-major or column-major: one FETCH, CAPTURE, HOLD pass per element.
module matrix_stream_reader #(
  parameter int DATA_W = 8,
  parameter int N      = 5,
  parameter int ADDR_W = 6
) (
  input logic                  clk,
  input logic                  reset,
  matrix_stream_reader_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [3:0] LAST_IDX = 4'(N - 1);

  logic [2:0]        r_state;
  logic [1:0]        r_mode;
  logic [ADDR_W-1:0] r_base_a;
  logic [ADDR_W-1:0] r_base_b;
  logic [ADDR_W-1:0] r_addr_a;
  logic [ADDR_W-1:0] r_addr_b;
  logic [3:0]        r_row;
  logic [3:0]        r_col;
  logic [DATA_W-1:0] r_out_a;
  logic [DATA_W-1:0] r_out_b;
  logic              r_out_last;

  logic [3:0]        w_row_nxt;
  logic [3:0]        w_col_nxt;
  logic [1:0]        w_mode;
  logic [ADDR_W-1:0] w_base_a;
  logic [ADDR_W-1:0] w_base_b;
  logic [ADDR_W-1:0] w_off_rm;
  logic [ADDR_W-1:0] w_off_cm;
  logic [ADDR_W-1:0] w_addr_a;
  logic [ADDR_W-1:0] w_addr_b;
  logic              w_at_end;

  // Address of the element about to be fetched; in IDLE the live inputs are used so
  // the first address is ready in the same edge that captures them.
  always_comb begin
    w_at_end = (r_row == LAST_IDX) && (r_col == LAST_IDX);
    if (r_state == S_IDLE) begin
      w_row_nxt = '0;
      w_col_nxt = '0;
      w_mode    = bus.mode;
      w_base_a  = bus.base_a;
      w_base_b  = bus.base_b;
    end else begin
      w_mode   = r_mode;
      w_base_a = r_base_a;
      w_base_b = r_base_b;
      if (r_col == LAST_IDX) begin
        w_col_nxt = '0;
        w_row_nxt = r_row + 4'd1;
      end else begin
        w_col_nxt = r_col + 4'd1;
        w_row_nxt = r_row;
      end
    end
    w_off_rm = ADDR_W'(w_row_nxt) * ADDR_W'(N) + ADDR_W'(w_col_nxt);
    w_off_cm = ADDR_W'(w_col_nxt) * ADDR_W'(N) + ADDR_W'(w_row_nxt);
    w_addr_a = w_base_a + (w_mode[0] ? w_off_cm : w_off_rm);
    w_addr_b = w_base_b + (w_mode[1] ? w_off_cm : w_off_rm);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_mode     <= '0;
      r_base_a   <= '0;
      r_base_b   <= '0;
      r_addr_a   <= '0;
      r_addr_b   <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_out_a    <= '0;
      r_out_b    <= '0;
      r_out_last <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mode   <= bus.mode;
            r_base_a <= bus.base_a;
            r_base_b <= bus.base_b;
            r_row    <= '0;
            r_col    <= '0;
            r_addr_a <= w_addr_a;
            r_addr_b <= w_addr_b;
            r_state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_out_a    <= bus.mem_a_rdata;
          r_out_b    <= bus.mem_b_rdata;
          r_out_last <= w_at_end;
          r_state    <= S_HOLD;
        end
        S_HOLD: begin
          // Indices and addresses only advance on an accepted transfer.
          if (bus.out_ready) begin
            if (r_out_last) begin
              r_state <= S_DONE;
            end else begin
              r_row    <= w_row_nxt;
              r_col    <= w_col_nxt;
              r_addr_a <= w_addr_a;
              r_addr_b <= w_addr_b;
              r_state  <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_a_addr = r_addr_a;
  assign bus.mem_b_addr = r_addr_b;
  assign bus.mem_rd_en  = (r_state == S_FETCH);
  assign bus.out_a      = r_out_a;
  assign bus.out_b      = r_out_b;
  assign bus.out_last   = r_out_last;
  assign bus.out_valid  = (r_state == S_HOLD);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = (r_state == S_DONE);

endmodule

// File: tb/tb_matrix_stream_reader.sv
// Self-checking bench for matrix_stream_reader: memories hold A[x]=2x and B[x]=3x, and a
// per-run model of the expected address and element sequences is checked on every cycle.
module tb_matrix_stream_reader;

  localparam int DATA_W = 8;
  localparam int N      = 5;
  localparam int ADDR_W = 6;
  localparam int NN     = N * N;
  localparam int MEM_SZ = 1 << ADDR_W;

  logic clk;
  logic reset;

  matrix_stream_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  matrix_stream_reader #(.DATA_W(DATA_W), .N(N), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  int expAddrA [0:63];
  int expAddrB [0:63];
  int expA     [0:63];
  int expB     [0:63];
  int logAddrA [0:63];
  int logAddrB [0:63];
  int logOutA  [0:63];
  int logOutB  [0:63];

  int runId = 0;
  int seenRun = 0;
  bit armed = 0;
  int negCount = 0;
  int rdIdx = 0;
  int xferIdx = 0;
  int doneCount = 0;
  int doneNeg = 0;
  int firstBusyNeg = -1;
  int firstValidNeg = -1;
  int lastXferNeg = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memories: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      bus.mem_a_rdata <= DATA_W'(2 * int'(bus.mem_a_addr));
      bus.mem_b_rdata <= DATA_W'(3 * int'(bus.mem_b_addr));
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Element k sits at row k/N, column k%N; column-major swaps the roles in the offset.
  task automatic buildModel(input logic [1:0] mode, input int baseA, input int baseB);
    for (int k = 0; k < NN; k++) begin
      int i;
      int j;
      int offA;
      int offB;
      i = k / N;
      j = k % N;
      offA = mode[0] ? (j * N + i) : (i * N + j);
      offB = mode[1] ? (j * N + i) : (i * N + j);
      expAddrA[k] = (baseA + offA) % MEM_SZ;
      expAddrB[k] = (baseB + offB) % MEM_SZ;
      expA[k] = (2 * expAddrA[k]) % 256;
      expB[k] = (3 * expAddrB[k]) % 256;
    end
  endtask

  always @(negedge clk) begin
    negCount++;
    if (runId != seenRun) begin
      seenRun = runId;
      rdIdx = 0;
      xferIdx = 0;
      doneCount = 0;
      doneNeg = 0;
      firstBusyNeg = -1;
      firstValidNeg = -1;
      lastXferNeg = 0;
    end
    if (bus.done) begin
      doneCount++;
      doneNeg = negCount;
    end
    if (armed) begin
      if (bus.busy && firstBusyNeg < 0) firstBusyNeg = negCount;
      if (bus.mem_rd_en) begin
        if (rdIdx < NN) begin
          checkOutput("addr_a", int'(bus.mem_a_addr), expAddrA[rdIdx]);
          checkOutput("addr_b", int'(bus.mem_b_addr), expAddrB[rdIdx]);
          logAddrA[rdIdx] = int'(bus.mem_a_addr);
          logAddrB[rdIdx] = int'(bus.mem_b_addr);
        end else begin
          checkOutput("read_count", rdIdx, NN - 1);
        end
        rdIdx++;
      end
      if (bus.out_valid) begin
        if (firstValidNeg < 0) firstValidNeg = negCount;
        if (xferIdx < NN) begin
          checkOutput("out_a", int'(bus.out_a), expA[xferIdx]);
          checkOutput("out_b", int'(bus.out_b), expB[xferIdx]);
          checkOutput("out_last", int'(bus.out_last), int'(xferIdx == NN - 1));
          if (bus.out_ready) begin
            logOutA[xferIdx] = int'(bus.out_a);
            logOutB[xferIdx] = int'(bus.out_b);
            xferIdx++;
            lastXferNeg = negCount;
          end
        end else begin
          checkOutput("xfer_count", xferIdx, NN - 1);
        end
      end
    end
  end

  // One start request; optional stall, mid-stream reset and stray start pulses.
  task automatic applyStimulus(input logic [1:0] mode, input int baseA, input int baseB,
                               input int stallAt, input int stallA, input int stallB,
                               input int resetAt, input bit noise, input bit checkTiming);
    int  budget;
    bit  finished;
    bit  stalled;
    runId++;
    buildModel(mode, baseA, baseB);
    armed = 1;
    bus.mode = mode;
    bus.base_a = ADDR_W'(baseA);
    bus.base_b = ADDR_W'(baseB);
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.mode = ~mode;
    bus.base_a = ADDR_W'(baseA + 7);
    bus.base_b = ADDR_W'(baseB + 11);
    budget = 0;
    finished = 0;
    stalled = 0;
    while (!finished && budget < 2000) begin
      budget++;
      bus.start = noise && (budget == 20 || budget == 41);
      if (bus.out_valid && xferIdx == stallAt && !stalled) begin
        bus.out_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
          @(posedge clk); #1;
          checkOutput("stall_valid", int'(bus.out_valid), 1);
          checkOutput("stall_rd_en", int'(bus.mem_rd_en), 0);
          checkOutput("stall_a", int'(bus.out_a), stallA);
          checkOutput("stall_b", int'(bus.out_b), stallB);
        end
        bus.out_ready = 1'b1;
        stalled = 1;
      end
      if (bus.out_valid && xferIdx == resetAt) begin
        armed = 0;
        bus.out_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("rst_out_a", int'(bus.out_a), 0);
        checkOutput("rst_out_b", int'(bus.out_b), 0);
        checkOutput("rst_valid", int'(bus.out_valid), 0);
        checkOutput("rst_last", int'(bus.out_last), 0);
        checkOutput("rst_busy", int'(bus.busy), 0);
        checkOutput("rst_done", int'(bus.done), 0);
        checkOutput("rst_rd_en", int'(bus.mem_rd_en), 0);
        checkOutput("rst_addr_a", int'(bus.mem_a_addr), 0);
        checkOutput("rst_addr_b", int'(bus.mem_b_addr), 0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("rst_no_done", doneCount, 0);
        bus.out_ready = 1'b1;
        return;
      end
      if (bus.done) begin
        finished = 1;
        bus.start = noise;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!finished) checkOutput("stream_timeout", budget, 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    checkOutput("done_pulse_width", int'(bus.done), 0);
    checkOutput("idle_after_done", int'(bus.busy), 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("busy_stays_idle", int'(bus.busy), 0);
    checkOutput("done_count", doneCount, 1);
    checkOutput("xfer_total", xferIdx, NN);
    checkOutput("read_total", rdIdx, NN);
    checkOutput("done_after_last", doneNeg - lastXferNeg, 1);
    if (checkTiming) begin
      checkOutput("first_valid_lat", firstValidNeg - firstBusyNeg, 2);
      checkOutput("start_to_done", doneNeg - firstBusyNeg, 75);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.mode = 2'b00;
    bus.base_a = '0;
    bus.base_b = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("init_valid", int'(bus.out_valid), 0);
    checkOutput("init_busy", int'(bus.busy), 0);
    checkOutput("init_out_a", int'(bus.out_a), 0);
    checkOutput("init_addr_a", int'(bus.mem_a_addr), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    applyStimulus(2'b00, 0, 0, -1, 0, 0, -1, 1'b0, 1'b1);
    checkOutput("pin_pair2_a", logOutA[1], 2);
    checkOutput("pin_pair2_b", logOutB[1], 3);
    checkOutput("pin_pair25_a", logOutA[24], 48);
    checkOutput("pin_pair25_b", logOutB[24], 72);
    checkOutput("hold_after_done_a", int'(bus.out_a), 48);
    checkOutput("hold_after_done_b", int'(bus.out_b), 72);

    applyStimulus(2'b00, 0, 0, 2, 4, 6, -1, 1'b0, 1'b0);

    applyStimulus(2'b10, 0, 0, -1, 0, 0, -1, 1'b0, 1'b1);
    checkOutput("pin_colB_pair2_b", logOutB[1], 15);
    checkOutput("pin_colB_pair2_a", logOutA[1], 2);
    checkOutput("pin_colB_addr1", logAddrB[1], 5);
    checkOutput("pin_colB_addr5", logAddrB[5], 1);
    checkOutput("pin_colB_addr24", logAddrB[24], 24);

    applyStimulus(2'b00, 60, 0, -1, 0, 0, -1, 1'b0, 1'b1);
    checkOutput("pin_wrap_addr0", logAddrA[0], 60);
    checkOutput("pin_wrap_addr3", logAddrA[3], 63);
    checkOutput("pin_wrap_addr4", logAddrA[4], 0);
    checkOutput("pin_wrap_addr24", logAddrA[24], 20);

    applyStimulus(2'b11, 3, 40, -1, 0, 0, -1, 1'b0, 1'b1);

    applyStimulus(2'b00, 0, 0, -1, 0, 0, 9, 1'b0, 1'b0);
    applyStimulus(2'b00, 0, 0, -1, 0, 0, -1, 1'b0, 1'b1);
    checkOutput("pin_restart_addr0", logAddrA[0], 0);

    applyStimulus(2'b00, 0, 0, -1, 0, 0, -1, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
